// File: rtl/filter_loader_pkg.sv
// Shared types and constants for the 3x3x3 filter bank loader.
// Geometry constants, FSM state enum and default weight/filter typedefs.
package filter_loader_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StFinish
    } state_e;

    localparam int unsigned KSIZE            = 3;
    localparam int unsigned NCHAN            = 3;
    localparam int unsigned BEATS_PER_FILTER = KSIZE * KSIZE * NCHAN;
    localparam int unsigned DEFAULT_WIDTH    = 8;

    typedef logic [DEFAULT_WIDTH-1:0] weight_t;
    typedef weight_t [KSIZE-1:0][KSIZE-1:0][NCHAN-1:0] filter_t;

    // Out-of-range filter selects collapse onto the highest filter.
    function automatic int unsigned clamp_sel(input int unsigned sel, input int unsigned num);
        return (sel >= num) ? (num - 1) : sel;
    endfunction

endpackage

// File: rtl/filter_index_counter.sv
// Row/column/channel/filter counter chain; channel is the fastest-moving digit.
// last_beat flags the final position of either one filter or the whole bank.
module filter_index_counter
    import filter_loader_pkg::*;
#(
    parameter int unsigned NUM_FILTERS = 4,
    parameter int unsigned FW          = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic [FW-1:0] preset_filt,
    input  logic          inc,
    input  logic          single,
    output logic [FW-1:0] filt,
    output logic [1:0]    row,
    output logic [1:0]    col,
    output logic [1:0]    chan,
    output logic          last_beat
);

    logic [FW-1:0] filt_q, filt_d;
    logic [1:0]    row_q, row_d;
    logic [1:0]    col_q, col_d;
    logic [1:0]    chan_q, chan_d;

    logic chan_wrap, col_wrap, row_wrap, filt_wrap;

    assign chan_wrap = (chan_q == 2'(NCHAN - 1));
    assign col_wrap  = (col_q == 2'(KSIZE - 1));
    assign row_wrap  = (row_q == 2'(KSIZE - 1));
    assign filt_wrap = (filt_q == FW'(NUM_FILTERS - 1));

    always_comb begin
        filt_d = filt_q;
        row_d  = row_q;
        col_d  = col_q;
        chan_d = chan_q;
        if (clear) begin
            filt_d = preset_filt;
            row_d  = '0;
            col_d  = '0;
            chan_d = '0;
        end else if (inc) begin
            chan_d = chan_wrap ? 2'd0 : chan_q + 2'd1;
            if (chan_wrap) begin
                col_d = col_wrap ? 2'd0 : col_q + 2'd1;
                if (col_wrap) begin
                    row_d = row_wrap ? 2'd0 : row_q + 2'd1;
                    if (row_wrap) begin
                        filt_d = filt_wrap ? '0 : filt_q + FW'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q <= '0;
            row_q  <= '0;
            col_q  <= '0;
            chan_q <= '0;
        end else begin
            filt_q <= filt_d;
            row_q  <= row_d;
            col_q  <= col_d;
            chan_q <= chan_d;
        end
    end

    assign filt      = filt_q;
    assign row       = row_q;
    assign col       = col_q;
    assign chan      = chan_q;
    assign last_beat = chan_wrap && col_wrap && row_wrap && (single || filt_wrap);

endmodule

// File: rtl/filter_loader.sv
// Streams weights into a bank of 3x3x3 filters, either the whole bank or one filter.
// bank_valid reports that every filter has been written at least once since reset.
module filter_loader
    import filter_loader_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned NUM_FILTERS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             load_all,
    input  logic [1:0]       load_sel,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [NUM_FILTERS-1:0][KSIZE-1:0][KSIZE-1:0][NCHAN-1:0][WIDTH-1:0] filters,
    output logic             busy,
    output logic             done,
    output logic             bank_valid
);

    localparam int unsigned FW = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;

    typedef logic [NUM_FILTERS-1:0][KSIZE-1:0][KSIZE-1:0][NCHAN-1:0][WIDTH-1:0] bank_t;

    state_e state_q, state_d;

    logic                   all_q, all_d;
    logic [FW-1:0]          sel_q, sel_d;
    bank_t                  filters_q, filters_d;
    logic [NUM_FILTERS-1:0] written_q, written_d;

    logic          accept;
    logic          cnt_clear;
    logic [FW-1:0] sel_clamped;
    logic [FW-1:0] preset_filt;
    logic [FW-1:0] filt;
    logic [1:0]    row, col, chan;
    logic          last_beat;

    assign accept      = (state_q == StLoad) && s_valid;
    assign cnt_clear   = (state_q == StIdle) && start;
    assign sel_clamped = FW'(clamp_sel(32'(load_sel), NUM_FILTERS));
    assign preset_filt = load_all ? '0 : sel_clamped;

    filter_index_counter #(
        .NUM_FILTERS (NUM_FILTERS),
        .FW          (FW)
    ) u_index (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (cnt_clear),
        .preset_filt (preset_filt),
        .inc         (accept),
        .single      (~all_q),
        .filt        (filt),
        .row         (row),
        .col         (col),
        .chan        (chan),
        .last_beat   (last_beat)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; start is only looked at in idle
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start) state_d = StLoad;
            StLoad:   if (accept && last_beat) state_d = StFinish;
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        s_ready = (state_q == StLoad);
        busy    = (state_q == StLoad) || (state_q == StFinish);
        done    = (state_q == StFinish);
    end

    always_comb begin
        all_d     = all_q;
        sel_d     = sel_q;
        filters_d = filters_q;
        written_d = written_q;
        if (cnt_clear) begin
            all_d = load_all;
            sel_d = sel_clamped;
        end
        if (accept) begin
            filters_d[filt][row][col][chan] = s_data;
        end
        // Written flags commit only on completion so an aborted load never counts.
        if (state_q == StFinish) begin
            if (all_q) begin
                written_d = '1;
            end else begin
                written_d[sel_q] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            all_q     <= 1'b0;
            sel_q     <= '0;
            filters_q <= '0;
            written_q <= '0;
        end else begin
            all_q     <= all_d;
            sel_q     <= sel_d;
            filters_q <= filters_d;
            written_q <= written_d;
        end
    end

    assign filters    = filters_q;
    assign bank_valid = &written_q;

endmodule

// File: tb/tb_filter_loader.sv
// Self-checking bench for filter_loader: table of load scenarios, per-beat scoreboard
// of expected writes, and a reference copy of the bank for whole-content comparison.
module tb_filter_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       load_all;
    logic [1:0] load_sel;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic [3:0][2:0][2:0][2:0][7:0] filters;
    logic       busy;
    logic       done;
    logic       bank_valid;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int         f;
        int         r;
        int         c;
        int         ch;
        logic [7:0] d;
    } wr_t;

    typedef struct {
        bit         rst;
        bit         all;
        logic [1:0] sel;
        bit         cnst;
        logic [7:0] cval;
        bit         toggle;
        int         restart_at;
        int         abort_at;
        bit         spot;
        bit         exp_bv;
    } vec_t;

    wr_t        sb[$];
    logic [7:0] model[4][3][3][3];
    vec_t       tbl[10];

    filter_loader #(
        .WIDTH       (8),
        .NUM_FILTERS (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .load_all   (load_all),
        .load_sel   (load_sel),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .filters    (filters),
        .busy       (busy),
        .done       (done),
        .bank_valid (bank_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_model();
        for (int f = 0; f < 4; f++)
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    for (int ch = 0; ch < 3; ch++)
                        model[f][r][c][ch] = 8'h00;
        sb.delete();
    endtask

    task automatic compare_bank(input string name);
        bit miss = 0;
        total++;
        for (int f = 0; f < 4; f++)
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    for (int ch = 0; ch < 3; ch++)
                        if (!miss && filters[f][r][c][ch] !== model[f][r][c][ch]) begin
                            miss = 1;
                            bad++;
                            $display("FAIL %s: [%0d][%0d][%0d][%0d] got %0h expected %0h", name,
                                     f, r, c, ch, filters[f][r][c][ch], model[f][r][c][ch]);
                        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        start    = 1'b0;
        load_all = 1'b0;
        load_sel = 2'd0;
        s_valid  = 1'b0;
        s_data   = 8'h00;
        clear_model();
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ready", 32'(s_ready), 32'd0);
        check("rst_bank_valid", 32'(bank_valid), 32'd0);
        compare_bank("rst_bank");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_load(input vec_t v);
        int f0, beats, acc, cyc, last_cyc, early;
        bit fin, aborted;
        wr_t w;
        f0       = v.all ? 0 : ((int'(v.sel) > 3) ? 3 : int'(v.sel));
        beats    = v.all ? 108 : 27;
        acc      = 0;
        cyc      = 0;
        last_cyc = 0;
        early    = 0;
        fin      = 0;
        aborted  = 0;
        @(negedge clk);
        start    = 1'b1;
        load_all = v.all;
        load_sel = v.sel;
        s_valid  = 1'b0;
        @(negedge clk);
        load_all = ~v.all;
        load_sel = ~v.sel;
        while (!fin && cyc < 400) begin
            start   = (v.restart_at > 0 && acc == v.restart_at) ? 1'b1 : 1'b0;
            s_valid = v.toggle ? (cyc % 2 == 0) : 1'b1;
            s_data  = v.cnst ? v.cval : 8'(acc + int'(v.cval));
            if (s_valid && s_ready) begin
                w.f  = f0 + acc / 27;
                w.r  = (acc % 27) / 9;
                w.c  = (acc % 9) / 3;
                w.ch = acc % 3;
                w.d  = s_data;
                sb.push_back(w);
                model[w.f][w.r][w.c][w.ch] = w.d;
                acc++;
                if (acc == beats) begin
                    fin      = 1;
                    last_cyc = cyc + 1;
                end
            end
            cyc++;
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                w = sb.pop_front();
                check("beat_write", 32'(filters[w.f][w.r][w.c][w.ch]), 32'(w.d));
            end
            if (!fin && done) early++;
            if (v.abort_at > 0 && acc == v.abort_at) begin
                aborted = 1;
                break;
            end
            if (!fin) @(negedge clk);
        end
        start = 1'b0;
        if (aborted) begin
            #2;
            rst_n = 1'b0;
            clear_model();
            #1;
            compare_bank("abort_bank_zero");
            check("abort_busy", 32'(busy), 32'd0);
            check("abort_bank_valid", 32'(bank_valid), 32'd0);
            check("abort_ready", 32'(s_ready), 32'd0);
            @(negedge clk);
            s_valid = 1'b0;
            rst_n   = 1'b1;
            for (int i = 0; i < 5; i++) begin
                @(posedge clk);
                #1;
                if (done) early++;
            end
            check("abort_no_done", 32'(early), 32'd0);
            check("abort_idle_busy", 32'(busy), 32'd0);
            return;
        end
        check("load_finished", 32'(fin), 32'd1);
        check("done_not_early", 32'(early), 32'd0);
        check("done_after_last", 32'(done), 32'd1);
        check("ready_drop", 32'(s_ready), 32'd0);
        check("beat_cycles", 32'(last_cyc), 32'(v.toggle ? 2 * beats - 1 : beats));
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = 8'hEE;
        @(posedge clk);
        #1;
        check("done_one_cycle", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        s_valid = 1'b0;
        compare_bank("bank_contents");
        if (v.spot) begin
            check("f1_000", 32'(filters[1][0][0][0]), 32'd27);
            check("f3_222", 32'(filters[3][2][2][2]), 32'd107);
        end
        check("bank_valid", 32'(bank_valid), 32'(v.exp_bv));
    endtask

    initial begin
        //          rst  all  sel   cnst cval   tgl rst_at abort spot bv
        tbl[0] = '{1'b1, 1'b0, 2'd0, 1'b1, 8'h10, 1'b0, 0, 0,  1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 2'd1, 1'b1, 8'h11, 1'b0, 0, 0,  1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 2'd2, 1'b1, 8'h12, 1'b0, 0, 0,  1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 2'd3, 1'b1, 8'h13, 1'b0, 0, 0,  1'b0, 1'b1};
        tbl[4] = '{1'b1, 1'b1, 2'd2, 1'b0, 8'h00, 1'b0, 0, 0,  1'b1, 1'b1};
        tbl[5] = '{1'b0, 1'b0, 2'd2, 1'b1, 8'hAA, 1'b0, 0, 0,  1'b0, 1'b1};
        tbl[6] = '{1'b1, 1'b1, 2'd1, 1'b0, 8'h00, 1'b1, 0, 0,  1'b1, 1'b1};
        tbl[7] = '{1'b0, 1'b1, 2'd1, 1'b0, 8'h40, 1'b0, 10, 0, 1'b0, 1'b1};
        tbl[8] = '{1'b0, 1'b1, 2'd0, 1'b0, 8'h00, 1'b0, 0, 50, 1'b0, 1'b0};
        tbl[9] = '{1'b0, 1'b0, 2'd1, 1'b1, 8'h5A, 1'b0, 0, 0,  1'b0, 1'b0};

        do_reset();
        // Weights offered while idle must not land anywhere.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = 8'h55;
        end
        @(negedge clk);
        s_valid = 1'b0;
        compare_bank("idle_valid_ignored");
        check("idle_ready", 32'(s_ready), 32'd0);

        for (int i = 0; i < 10; i++) begin
            if (tbl[i].rst) do_reset();
            run_load(tbl[i]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/filter_loader.md
FILTER_LOADER -- requirements
Module: filter_loader

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the bit width of one filter weight.
REQ-002 SHALL have parameter NUM_FILTERS, default 4, meaning the number of 3x3x3 filters held in the bank.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: single-cycle request to begin a load.
REQ-006 SHALL have port load_all, input, 1 bit: sampled with start; 1 = reload all filters, 0 = reload one filter.
REQ-007 SHALL have port load_sel, input, 2 bits: sampled with start; the filter index reloaded when load_all=0.
REQ-008 SHALL have port s_data, input, WIDTH bits: incoming weight.
REQ-009 SHALL have port s_valid, input, 1 bit: s_data is valid.
REQ-010 SHALL have port s_ready, output, 1 bit: loader accepts a weight this cycle.
REQ-011 SHALL have port filters, output, WIDTH x [NUM_FILTERS][3][3][3]: stored bank, indexed [filter][row][column][channel].
REQ-012 SHALL have port busy, output, 1 bit: a load is in progress.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse when a load completes.
REQ-014 SHALL have port bank_valid, output, 1 bit: every filter has been written at least once since reset.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD and FINISH.
REQ-016 IDLE -> LOAD SHALL occur on start=1; capture load_all/load_sel; start filter counter at 0 (load_all=1) or load_sel (load_all=0); row/col/channel counters at 0.
REQ-017 s_ready SHALL be 1 exactly in LOAD; a beat is accepted on s_valid && s_ready.
REQ-018 An accepted beat SHALL write s_data to filters[f][r][c][ch], visible on the next cycle.
REQ-019 Write order SHALL be: channel fastest (0..2), then column, then row, then filter; each counter wraps 2 -> 0 and carries.
REQ-020 The last beat (27th for a single filter; 27*NUM_FILTERS, i.e. 108, for all) SHALL move LOAD -> FINISH, deasserting s_ready the following cycle.
REQ-021 FINISH SHALL last one cycle with done=1, then return to IDLE.
REQ-022 bank_valid SHALL set in FINISH after a load_all load, or once every filter index has completed a single-filter load (per-filter written flags).
REQ-023 busy SHALL be 1 in LOAD and FINISH, otherwise 0.
REQ-024 start SHALL be ignored while busy=1.
REQ-025 Cycles with s_valid=0 in LOAD SHALL stall the counters without writing.
REQ-026 s_valid in IDLE or FINISH SHALL be ignored with no write.
REQ-027 Untouched filters SHALL keep their contents during a single-filter load.
REQ-028 load_sel >= NUM_FILTERS SHALL be clamped to NUM_FILTERS-1.
REQ-029 Accepted-beat throughput SHALL be one weight per cycle with no bubbles.

Reset
REQ-030 rst_n=0 SHALL asynchronously force state IDLE, all counters 0, all filters entries 0, written flags 0, s_ready=0, busy=0, done=0 and bank_valid=0.
REQ-031 Reset asserted mid-LOAD SHALL abort the load with no done pulse; after release the block is in IDLE.

Structure
REQ-032 A shared package SHALL hold the FSM state enum, the constants KSIZE=3, NCHAN=3 and BEATS_PER_FILTER=27, and the weight/filter-bank typedefs shared with the channel-selection mux.
REQ-033 The row/col/channel/filter counter chain SHALL be one sub-module, filter_index_counter, with increment enable, clear, preset-filter input and a last-beat flag output.

Verification
REQ-034 Reset, start with load_all=1, 108 back-to-back beats with data=index mod 256 -> filters[1][0][0][0]=27, filters[3][2][2][2]=107, done pulse one cycle after the 108th beat, bank_valid=1.
REQ-035 After the full load, start with load_all=0, load_sel=2, 27 beats of 0xAA -> filter 2 all 0xAA, filters 0/1/3 unchanged, done pulses once.
REQ-036 Full load with s_valid toggled 1,0,1,0... -> 108 writes in 215 cycles, contents identical to REQ-034.
REQ-037 Pulse start again after beat 10 of a load -> ignored, load completes after beat 108 unchanged.
REQ-038 Assert rst_n=0 after beat 50 -> all filters 0, busy=0, bank_valid=0 with no clock edge; no done pulse.
REQ-039 From reset, single-filter loads of indices 0,1,2 -> bank_valid stays 0; after index 3 -> bank_valid=1.
